// File: rtl/imem_boot_loader_if.sv
// Stream-in and IMEM-write bus of the instruction-memory boot loader.
// The loader masters the IMEM write port and consumes the stream; the environment is the slave.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 9
);
    // Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
    // rx_data must stay stable while rx_valid is high and the byte has not transferred.
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a framed byte stream (LEN_HI, LEN_LO, payload, CSUM) into IMEM from address 0
// and releases the core only after a frame with a good checksum has been written.
module imem_boot_loader #(
    parameter int ADDR_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    imem_boot_loader_if.master         bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       core_run,
    output logic [2:0]                 state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0]   TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [16:0]     CAPACITY = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            sum_q, sum_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  core_run_q, core_run_d;

    logic                  acc;
    logic                  busy_now;
    logic                  timed_out;
    logic [16:0]           len17;
    logic [7:0]            csum_chk;
    logic                  busy_next;

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        timer_d     = timer_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        acc       = bus.rx_valid && rx_ready_q;
        busy_now  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
        timed_out = TO_EN && busy_now && !acc && (timer_q == TO_LAST);
        len17     = {1'b0, len_hi_q, bus.rx_data};
        csum_chk  = sum_q + bus.rx_data;

        // The idle timer reloads on every accepted byte while a load is active.
        if (busy_now) begin
            timer_d = acc ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d  = S_LEN_HI;
                    len_hi_d = '0;
                    rem_d    = '0;
                    addr_d   = '0;
                    sum_d    = '0;
                    timer_d  = '0;
                end
            end
            S_LEN_HI: begin
                if (acc) begin
                    len_hi_d = bus.rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (acc) begin
                    rem_d = len17[ADDR_WIDTH:0];
                    if (len17 > CAPACITY) begin
                        state_d = S_ERROR;
                    end else if (len17 == 17'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.rx_data;
                    sum_d       = csum_chk;
                    rem_d       = rem_q - 1'b1;
                    // Hold the address on the final byte so a full-capacity frame never wraps.
                    if (rem_q == REM_ONE) begin
                        state_d = S_CSUM;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (acc) begin
                    state_d = (csum_chk == 8'd0) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timed_out) begin
            state_d = S_ERROR;
        end

        busy_next  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CSUM);
        rx_ready_d = busy_next;
        busy_d     = busy_next;
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERROR);
        core_run_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_hi_q    <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            timer_q     <= '0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            core_run_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            timer_q     <= timer_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            core_run_q  <= core_run_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign core_run      = core_run_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: drives frames, scoreboards every IMEM write, checks status levels.
module tb_imem_boot_loader;
  localparam int AW = 9;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, done, err, core_run;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [AW-1:0] last_addr;
  logic [AW+7:0] exp_q[$];

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err), .core_run(core_run), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      wr_cnt++;
      last_addr = bus.mem_addr;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", exp_q.size(), 1);
      end else begin
        logic [AW+7:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e[AW+7:8]);
        chk("wr_data", bus.mem_wdata, e[7:0]);
      end
    end
  end

  // drivers
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) chk("rx_ready_timeout", bus.rx_ready, 1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_payload(input int len, input int max_gap, output logic [7:0] sum);
    logic [7:0] b;
    sum = 8'd0;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back({AW'(i), b});
      sum = sum + b;
      send_byte(b, $urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_status();
    int n = 0;
    while (!(done || err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("status_seen", done | err, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_core_run"}, core_run, 0);
    chk({tag, "_rx_ready"}, bus.rx_ready, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  logic [7:0] t1_bytes [8];
  logic [7:0] sum;

  initial begin
    t1_bytes[0] = 8'h01; t1_bytes[1] = 8'hB0; t1_bytes[2] = 8'h80; t1_bytes[3] = 8'h93;
    t1_bytes[4] = 8'h10; t1_bytes[5] = 8'h03; t1_bytes[6] = 8'h83; t1_bytes[7] = 8'h93;
    rst = 1'b1;
    start = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: good frame; START arrives together with a valid byte that must not be consumed
    @(negedge clk);
    start = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b1;
    #1 chk("t1_start_rx_ready", bus.rx_ready, 0);
    @(negedge clk);
    start = 1'b0;
    chk("t1_busy", busy, 1);
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({AW'(i), t1_bytes[i]});
      send_byte(t1_bytes[i], 0);
    end
    send_byte(8'h13, 0);
    wait_status();
    chk("t1_done", done, 1);
    chk("t1_core_run", core_run, 1);
    chk("t1_err", err, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_writes", wr_cnt, 8);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_mem_we_idle", bus.mem_we, 0);
    chk("t1_addr_hold", bus.mem_addr, 7);

    // 2: same frame, bad checksum
    pulse_start();
    chk("t2_done_drop", done, 0);
    chk("t2_core_run_drop", core_run, 0);
    send_byte(8'h00, 1);
    send_byte(8'h08, 0);
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({AW'(i), t1_bytes[i]});
      send_byte(t1_bytes[i], $urandom_range(0, 2));
    end
    send_byte(8'h14, 0);
    wait_status();
    chk("t2_err", err, 1);
    chk("t2_core_run", core_run, 0);
    chk("t2_done", done, 0);
    chk("t2_writes", wr_cnt, 8);

    // 3: oversize length
    pulse_start();
    chk("t3_err_drop", err, 0);
    wr_cnt = 0;
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    chk("t3_err", err, 1);
    chk("t3_rx_ready", bus.rx_ready, 0);
    bus.rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_rx_ready_hold", bus.rx_ready, 0);
    bus.rx_valid = 1'b0;
    chk("t3_writes", wr_cnt, 0);

    // 4: idle timeout after 2 of 4 payload bytes
    pulse_start();
    wr_cnt = 0;
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_payload(2, 1, sum);
    repeat (1022) @(negedge clk);
    chk("t4_err_early", err, 0);
    chk("t4_busy_early", busy, 1);
    repeat (2) @(negedge clk);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_writes", wr_cnt, 2);

    // 5: full-capacity frame with random gaps
    pulse_start();
    wr_cnt = 0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_payload(512, 3, sum);
    send_byte(8'(8'd0 - sum), 2);
    wait_status();
    chk("t5_done", done, 1);
    chk("t5_core_run", core_run, 1);
    chk("t5_writes", wr_cnt, 512);
    chk("t5_last_addr", last_addr, 9'h1FF);
    chk("t5_q_empty", exp_q.size(), 0);

    // 6: reset mid-DATA, then a clean 4-byte load
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    send_payload(3, 0, sum);
    @(negedge clk);
    rst = 1'b1;
    #1 check_idle_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    chk("t6_q_empty", exp_q.size(), 0);
    pulse_start();
    wr_cnt = 0;
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_payload(4, 1, sum);
    send_byte(8'(8'd0 - sum), 0);
    wait_status();
    chk("t6_done", done, 1);
    chk("t6_writes", wr_cnt, 4);
    chk("t6_last_addr", last_addr, 3);
    chk("t6_q_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
